// File: rtl/trap_arbiter_pkg.sv
// Shared constants and types for the trap arbiter.
// Interrupt codes, priority order, CSR indices and FSM state.
package trap_arbiter_pkg;

    localparam logic [3:0] CAUSE_SSI = 4'd1;
    localparam logic [3:0] CAUSE_MSI = 4'd3;
    localparam logic [3:0] CAUSE_STI = 4'd5;
    localparam logic [3:0] CAUSE_MTI = 4'd7;
    localparam logic [3:0] CAUSE_SEI = 4'd9;
    localparam logic [3:0] CAUSE_MEI = 4'd11;

    localparam int NUM_IRQ = 6;

    // Highest priority first.
    localparam logic [3:0] IRQ_PRIO [NUM_IRQ] = '{
        CAUSE_MEI, CAUSE_MSI, CAUSE_MTI,
        CAUSE_SEI, CAUSE_SSI, CAUSE_STI
    };

    localparam logic [11:0] CSR_MIP = 12'h344;
    localparam logic [11:0] CSR_SIP = 12'h144;

    localparam logic [1:0] PRIV_U = 2'd0;
    localparam logic [1:0] PRIV_S = 2'd1;
    localparam logic [1:0] PRIV_M = 2'd3;

    localparam int MSTATUS_SIE = 1;
    localparam int MSTATUS_MIE = 3;

    typedef enum logic [1:0] {
        IDLE,
        PEND,
        BLOCK
    } arb_state_e;

    typedef struct packed {
        logic       hit;
        logic [3:0] code;
    } irq_pick_t;

    function automatic irq_pick_t irq_pick(input logic [11:0] en);
        irq_pick_t p;
        p = '0;
        // Walk lowest to highest so the strongest match is written last.
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (en[IRQ_PRIO[i]]) begin
                p.hit  = 1'b1;
                p.code = IRQ_PRIO[i];
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/trap_arbiter_irq_sync.sv
// Flop chain synchronising one asynchronous interrupt level.
// STAGES must be at least 2.
module irq_sync #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/trap_arbiter.sv
// Interrupt pending/enable arbitration, delegation and trap request
// generation, merged with synchronous exceptions at commit.
module trap_arbiter
    import trap_arbiter_pkg::*;
#(
    parameter int XLEN        = 64,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk_i,
    input  logic            arst_i,
    input  logic            ext_mei_i,
    input  logic            ext_mti_i,
    input  logic            ext_msi_i,
    input  logic            ext_sei_i,
    input  logic            csr_commit_valid,
    input  logic            csren,
    input  logic [11:0]     csrindex,
    input  logic [XLEN-1:0] csrdata,
    input  logic [XLEN-1:0] mstatus,
    input  logic [XLEN-1:0] mie,
    input  logic [XLEN-1:0] mideleg,
    input  logic [XLEN-1:0] medeleg,
    input  logic [1:0]      privilege,
    input  logic            instr_commit_valid,
    input  logic            exc_valid,
    input  logic [XLEN-1:0] exc_cause,
    output logic [XLEN-1:0] mip,
    output logic [XLEN-1:0] sip,
    output logic            int_req_o,
    output logic            trap_m,
    output logic            trap_s,
    output logic            trap_async,
    output logic [XLEN-1:0] trap_cause
);

    logic mei_s, mti_s, msi_s, sei_s;

    irq_sync #(.STAGES(SYNC_STAGES)) u_sync_mei (
        .clk_i(clk_i), .rst_i(arst_i), .d_i(ext_mei_i), .q_o(mei_s)
    );
    irq_sync #(.STAGES(SYNC_STAGES)) u_sync_mti (
        .clk_i(clk_i), .rst_i(arst_i), .d_i(ext_mti_i), .q_o(mti_s)
    );
    irq_sync #(.STAGES(SYNC_STAGES)) u_sync_msi (
        .clk_i(clk_i), .rst_i(arst_i), .d_i(ext_msi_i), .q_o(msi_s)
    );
    irq_sync #(.STAGES(SYNC_STAGES)) u_sync_sei (
        .clk_i(clk_i), .rst_i(arst_i), .d_i(ext_sei_i), .q_o(sei_s)
    );

    logic seip_q, stip_q, ssip_q;
    logic csr_wr;

    assign csr_wr = csr_commit_valid & csren;

    always_ff @(posedge clk_i) begin
        if (arst_i) begin
            seip_q <= 1'b0;
            stip_q <= 1'b0;
            ssip_q <= 1'b0;
        end else if (csr_wr && csrindex == CSR_MIP) begin
            seip_q <= csrdata[CAUSE_SEI];
            stip_q <= csrdata[CAUSE_STI];
            ssip_q <= csrdata[CAUSE_SSI];
        end else if (csr_wr && csrindex == CSR_SIP && mideleg[CAUSE_SSI]) begin
            ssip_q <= csrdata[CAUSE_SSI];
        end
    end

    always_comb begin
        mip            = '0;
        mip[CAUSE_MEI] = mei_s;
        mip[CAUSE_MTI] = mti_s;
        mip[CAUSE_MSI] = msi_s;
        mip[CAUSE_SEI] = sei_s | seip_q;
        mip[CAUSE_STI] = stip_q;
        mip[CAUSE_SSI] = ssip_q;
    end

    assign sip = mip & mideleg;

    logic        m_en, s_en;
    logic [11:0] cand, en_vec;

    assign m_en = (privilege != PRIV_M) | mstatus[MSTATUS_MIE];
    assign s_en = (privilege == PRIV_U)
                | ((privilege == PRIV_S) & mstatus[MSTATUS_SIE]);
    assign cand = mip[11:0] & mie[11:0];

    always_comb begin
        en_vec = '0;
        for (int i = 0; i < 12; i++) begin
            en_vec[i] = cand[i] & (mideleg[i] ? s_en : m_en);
        end
    end

    irq_pick_t  pick;
    arb_state_e state_q;
    logic [3:0] code_q;
    logic       tgt_s_q;
    logic       hold_ok;

    assign pick    = irq_pick(en_vec);
    assign hold_ok = en_vec[code_q];

    always_ff @(posedge clk_i) begin
        if (arst_i) begin
            state_q <= IDLE;
            code_q  <= '0;
            tgt_s_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (pick.hit) begin
                        state_q <= PEND;
                        code_q  <= pick.code;
                        tgt_s_q <= mideleg[pick.code];
                    end
                end
                PEND: begin
                    if (!hold_ok) begin
                        state_q <= IDLE;
                    end else if (instr_commit_valid) begin
                        state_q <= BLOCK;
                    end
                end
                BLOCK:   state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign int_req_o = (state_q == PEND);

    logic irq_fire, exc_fire, exc_s;

    // Reset wins over anything held, so nothing is issued on that cycle.
    assign irq_fire = !arst_i & int_req_o & instr_commit_valid & hold_ok;
    assign exc_fire = !arst_i & instr_commit_valid & exc_valid & !irq_fire;
    assign exc_s    = medeleg[exc_cause[5:0]] & (privilege != PRIV_M);

    always_comb begin
        trap_m     = 1'b0;
        trap_s     = 1'b0;
        trap_async = 1'b0;
        trap_cause = '0;
        if (irq_fire) begin
            trap_m     = !tgt_s_q;
            trap_s     = tgt_s_q;
            trap_async = 1'b1;
            trap_cause = {1'b1, {(XLEN-5){1'b0}}, code_q};
        end else if (exc_fire) begin
            trap_m     = !exc_s;
            trap_s     = exc_s;
            trap_cause = exc_cause;
        end
    end

    logic unused_ok;
    assign unused_ok = ^{1'b0, mstatus, mie, mideleg, medeleg, exc_cause};

endmodule

// File: tb/tb_trap_arbiter.sv
// Scoreboard bench for trap_arbiter: commit-cycle trap outputs are
// checked by a monitor against expectations queued by the stimulus.
module tb_trap_arbiter;

    localparam int XLEN = 64;
    localparam logic [63:0] IRQ = 64'h8000_0000_0000_0000;

    logic            clk = 1'b0;
    logic            arst_i = 1'b1;
    logic            ext_mei_i = 0, ext_mti_i = 0, ext_msi_i = 0, ext_sei_i = 0;
    logic            csr_commit_valid = 0, csren = 0;
    logic [11:0]     csrindex = '0;
    logic [XLEN-1:0] csrdata = '0;
    logic [XLEN-1:0] mstatus = '0, mie = '0, mideleg = '0, medeleg = '0;
    logic [1:0]      privilege = 2'd0;
    logic            instr_commit_valid = 0, exc_valid = 0;
    logic [XLEN-1:0] exc_cause = '0;
    logic [XLEN-1:0] mip, sip, trap_cause;
    logic            int_req_o, trap_m, trap_s, trap_async;

    trap_arbiter #(.XLEN(XLEN), .SYNC_STAGES(2)) dut (
        .clk_i(clk), .arst_i(arst_i),
        .ext_mei_i(ext_mei_i), .ext_mti_i(ext_mti_i),
        .ext_msi_i(ext_msi_i), .ext_sei_i(ext_sei_i),
        .csr_commit_valid(csr_commit_valid), .csren(csren),
        .csrindex(csrindex), .csrdata(csrdata),
        .mstatus(mstatus), .mie(mie), .mideleg(mideleg), .medeleg(medeleg),
        .privilege(privilege),
        .instr_commit_valid(instr_commit_valid),
        .exc_valid(exc_valid), .exc_cause(exc_cause),
        .mip(mip), .sip(sip), .int_req_o(int_req_o),
        .trap_m(trap_m), .trap_s(trap_s), .trap_async(trap_async),
        .trap_cause(trap_cause)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        m;
        logic        s;
        logic        a;
        logic [63:0] cause;
    } trap_t;

    trap_t exp_q[$];
    int    checks = 0;
    int    failures = 0;

    always @(negedge clk) begin
        trap_t got, e;
        if (instr_commit_valid === 1'b1) begin
            got = '{trap_m, trap_s, trap_async, trap_cause};
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL trap_unexpected: got m%b s%b a%b %h required none",
                         got.m, got.s, got.a, got.cause);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    failures++;
                    $display("FAIL trap: got m%b s%b a%b %h required m%b s%b a%b %h",
                             got.m, got.s, got.a, got.cause,
                             e.m, e.s, e.a, e.cause);
                end
            end
        end
    end

    task automatic tick(int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic commit(logic m, logic s, logic a, logic [63:0] c);
        exp_q.push_back('{m, s, a, c});
        instr_commit_valid = 1'b1;
        tick();
        instr_commit_valid = 1'b0;
    endtask

    task automatic csr_write(logic [11:0] idx, logic [63:0] d);
        csr_commit_valid = 1'b1;
        csren            = 1'b1;
        csrindex         = idx;
        csrdata          = d;
        tick();
        csr_commit_valid = 1'b0;
        csren            = 1'b0;
    endtask

    task automatic wait_req(string name);
        int n = 0;
        while (int_req_o !== 1'b1 && n < 8) begin
            tick();
            n++;
        end
        chk(name, {63'd0, int_req_o}, 64'd1);
    endtask

    initial begin
        tick(2);
        arst_i = 1'b0;
        chk("rst_mip", mip, 64'd0);
        chk("rst_sip", sip, 64'd0);
        chk("rst_req", {63'd0, int_req_o}, 64'd0);
        chk("rst_trap", {61'd0, trap_m, trap_s, trap_async}, 64'd0);
        chk("rst_cause", trap_cause, 64'd0);

        // MTI at U-mode, M target
        privilege = 2'd0;
        mie       = 64'h80;
        ext_mti_i = 1'b1;
        tick();
        chk("mtip_1cyc", mip & 64'h80, 64'h0);
        tick();
        chk("mtip_2cyc", mip & 64'h80, 64'h80);
        chk("req_early", {63'd0, int_req_o}, 64'd0);
        tick();
        chk("req_mti", {63'd0, int_req_o}, 64'd1);
        commit(1'b1, 1'b0, 1'b1, IRQ | 64'd7);
        ext_mti_i = 1'b0;
        mie       = '0;
        tick(4);
        chk("mti_clear", {63'd0, int_req_o}, 64'd0);

        // SSI delegated to S
        privilege = 2'd1;
        mideleg   = 64'h2;
        mstatus   = 64'h2;
        mie       = 64'h2;
        csr_write(12'h344, 64'h2);
        chk("ssip_mip", mip, 64'h2);
        chk("ssip_sip", sip, 64'h2);
        wait_req("req_ssi");
        commit(1'b0, 1'b1, 1'b1, IRQ | 64'd1);
        privilege = 2'd3;
        tick(4);
        chk("ssi_at_m", {63'd0, int_req_o}, 64'd0);
        commit(1'b0, 1'b0, 1'b0, 64'd0);
        mideleg = '0;
        csr_write(12'h344, 64'h0);
        chk("mip_clr", mip, 64'h0);
        csr_write(12'h144, 64'h2);
        chk("sip_wr_nodeleg", mip, 64'h0);
        mideleg = 64'h2;
        csr_write(12'h144, 64'h2);
        chk("sip_wr_deleg", sip, 64'h2);
        csr_write(12'h344, 64'h0);
        mie     = '0;
        mideleg = '0;
        mstatus = '0;

        // MEI and STI together: MEI first, STI after BLOCK
        privilege = 2'd0;
        ext_mei_i = 1'b1;
        csr_write(12'h344, 64'h20);
        tick(3);
        chk("mei_sti_mip", mip, 64'h820);
        mie = 64'h820;
        wait_req("req_mei");
        commit(1'b1, 1'b0, 1'b1, IRQ | 64'd11);
        mie = 64'h20;
        wait_req("req_sti");
        commit(1'b1, 1'b0, 1'b1, IRQ | 64'd5);
        mie       = '0;
        ext_mei_i = 1'b0;
        csr_write(12'h344, 64'h0);
        tick(3);

        // MIE cleared while held at M-mode
        privilege = 2'd3;
        mstatus   = 64'h8;
        mie       = 64'h8;
        ext_msi_i = 1'b1;
        wait_req("req_msi");
        mstatus = '0;
        tick();
        chk("msi_drop", {63'd0, int_req_o}, 64'd0);
        commit(1'b0, 1'b0, 1'b0, 64'd0);
        ext_msi_i = 1'b0;
        mie       = '0;
        tick(3);

        // Synchronous exceptions and delegation
        privilege = 2'd0;
        medeleg   = 64'h100;
        exc_valid = 1'b1;
        exc_cause = 64'd8;
        commit(1'b0, 1'b1, 1'b0, 64'd8);
        privilege = 2'd3;
        commit(1'b1, 1'b0, 1'b0, 64'd8);
        privilege = 2'd1;
        exc_cause = 64'd2;
        commit(1'b1, 1'b0, 1'b0, 64'd2);
        exc_valid = 1'b0;
        medeleg   = '0;

        // Interrupt beats exception, then reset while held
        privilege = 2'd0;
        mie       = 64'h80;
        ext_mti_i = 1'b1;
        wait_req("req_mti2");
        exc_valid = 1'b1;
        exc_cause = 64'd2;
        commit(1'b1, 1'b0, 1'b1, IRQ | 64'd7);
        exc_valid = 1'b0;
        csr_write(12'h344, 64'h222);
        wait_req("req_mti3");
        chk("mip_sw", mip, 64'h2A2);
        arst_i = 1'b1;
        commit(1'b0, 1'b0, 1'b0, 64'd0);
        arst_i    = 1'b0;
        ext_mti_i = 1'b0;
        chk("rst_pend_req", {63'd0, int_req_o}, 64'd0);
        chk("rst_pend_mip", mip, 64'h0);

        tick(2);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/trap_arbiter.md
Name: trap_arbiter

Overview:
- Produces the trap requests consumed by the trap setup unit: trap_m, trap_s, trap_async and trap_cause.
- Owns mip/sip: synchronises external interrupt lines, holds software-writable pending bits, arbitrates pending-and-enabled interrupts by priority and applies mideleg/medeleg delegation.
- Holds a chosen interrupt in a small FSM until the commit stage accepts it, and merges it with synchronous exceptions reported at commit.

Parameters:
- XLEN, 64, datapath width.
- SYNC_STAGES, 2, flop stages on each external interrupt line (minimum 2).

Ports:
- clk_i  in  1  clock
- arst_i  in  1  reset; synchronous, active-high
- ext_mei_i, ext_mti_i, ext_msi_i, ext_sei_i  in  1 each  asynchronous external interrupt levels (PLIC/CLINT)
- csr_commit_valid  in  1  CSR write commit strobe
- csren  in  1  CSR write enable
- csrindex  in  12  CSR address
- csrdata  in  XLEN  CSR write data
- mstatus, mie, mideleg, medeleg  in  XLEN each  current CSR values
- privilege  in  2  current privilege
- instr_commit_valid  in  1  an instruction is at commit this cycle
- exc_valid  in  1  committing instruction raised an exception
- exc_cause  in  XLEN  exception code (bit XLEN-1 = 0)
- mip, sip  out  XLEN each  pending registers
- int_req_o  out  1  interrupt held, waiting for commit
- trap_m, trap_s, trap_async  out  1 each  trap target and kind
- trap_cause  out  XLEN  mcause/scause value

Behaviour:
- Reset: sync chains, software SSIP/STIP/SEIP, FSM (IDLE) and held cause all cleared. All outputs read 0 in the cycle after reset.
- mip layout:
  - MEIP[11], MTIP[7], MSIP[3] equal the synchronised lines; read-only.
  - SEIP[9] = sync ext_sei OR software SEIP.
  - STIP[5], SSIP[1] are software bits.
- mip write (csr_commit_valid & csren & index 0x344): updates software SEIP/STIP/SSIP.
- sip write (0x144): updates SSIP only, and only if mideleg[1].
- sip read = mip & mideleg.
- Candidate set: cand = mip & mie.
  - Bit i targets S if mideleg[i], otherwise M.
  - M-target enabled iff privilege<M, or privilege==M & mstatus.MIE.
  - S-target enabled iff privilege==U, or privilege==S & mstatus.SIE; never enabled when privilege==M.
- Priority (highest first): MEI 11, MSI 3, MTI 7, SEI 9, SSI 1, STI 5.
- FSM:
  - IDLE: if any enabled candidate exists, latch its code and target; go to PEND next cycle (1-cycle arbitration latency).
  - PEND: int_req_o=1; held code and target stay stable.
    - Each cycle the hold condition is re-evaluated; if the held interrupt is no longer pending, masked or disabled, go to IDLE with no trap issued. A higher-priority arrival does not preempt.
    - If instr_commit_valid: issue the interrupt trap (trap_async=1, trap_cause={1,0...,code}, trap_m/trap_s per target); go to BLOCK. This takes precedence over exc_valid in the same cycle (instruction not retired).
  - BLOCK: one cycle with no interrupt arbitration, so the trap unit's MIE/SIE/privilege update settles; then go to IDLE.
- Exceptions: when instr_commit_valid & exc_valid and no interrupt is issued:
  - trap_async=0, trap_cause=exc_cause.
  - trap_s = medeleg[exc_cause[5:0]] & privilege!=M; trap_m = !trap_s.
  - Legal in every FSM state.
- trap_m/trap_s/trap_async/trap_cause are combinational and valid only while instr_commit_valid. Otherwise all zero.
- trap_m and trap_s are never both 1.
- Reset mid-PEND: the held interrupt is dropped, with no trap output on the reset cycle.

Decomposition:
- Shared package holds:
  - interrupt code constants (CAUSE_SSI/MSI/STI/MTI/SEI/MEI) and the priority order;
  - CSR indices 0x344/0x144;
  - the FSM state enum {IDLE, PEND, BLOCK}.
- Sub-module irq_sync: parameterised SYNC_STAGES flop chain, one instance per external line.

Test Plan:
- priv=U, mie.MTIE=1, mideleg=0; raise ext_mti_i -> MTIP visible after 2 cycles, int_req_o one cycle later; on commit trap_m=1, trap_async=1, trap_cause=0x8000_0000_0000_0007.
- priv=S, SSIP written via mip 0x2, mideleg=0x2, SIE=1 -> trap_s=1, cause 0x8000...0001. Same with priv=M -> no request.
- MEI and STI pending together, both enabled -> cause 11 issued first. After BLOCK, STI is issued if still pending and enabled.
- PEND held, then mstatus.MIE cleared (priv=M) before commit -> int_req_o drops next cycle, no trap on following commit.
- priv=U, medeleg bit 8 set, exc_valid with cause 8 -> trap_s=1, trap_async=0, cause 8. Same at priv=M -> trap_m=1.
- Exception and PEND interrupt on the same commit -> interrupt wins. Assert arst_i during PEND -> int_req_o=0 next cycle, mip software bits cleared.
